// File: rtl/vote_tally_arbiter_if.sv
// Booth handshake, control and display-counter bundle for the vote tally arbiter.
// The master side is the booths and front panel; the slave side is the arbiter.
interface vote_tally_arbiter_if #(
  parameter int CW = 29
);
  logic          voting_open;
  logic          clear;
  logic          DC_req;
  logic          MD_req;
  logic          VA_req;
  logic          DC_cand;
  logic          MD_cand;
  logic          VA_cand;
  logic          DC_ack;
  logic          MD_ack;
  logic          VA_ack;
  logic          reject;
  logic          busy;
  logic [CW-1:0] counter_DC_A;
  logic [CW-1:0] counter_DC_B;
  logic [CW-1:0] counter_DC_total;
  logic [CW-1:0] counter_MD_A;
  logic [CW-1:0] counter_MD_B;
  logic [CW-1:0] counter_MD_total;
  logic [CW-1:0] counter_VA_A;
  logic [CW-1:0] counter_VA_B;
  logic [CW-1:0] counter_VA_total;
  logic [CW-1:0] counter_A;
  logic [CW-1:0] counter_B;
  logic [CW-1:0] counter_total;

  modport master (
    output voting_open, clear,
    output DC_req, MD_req, VA_req, DC_cand, MD_cand, VA_cand,
    input  DC_ack, MD_ack, VA_ack, reject, busy,
    input  counter_DC_A, counter_DC_B, counter_DC_total,
    input  counter_MD_A, counter_MD_B, counter_MD_total,
    input  counter_VA_A, counter_VA_B, counter_VA_total,
    input  counter_A, counter_B, counter_total
  );

  modport slave (
    input  voting_open, clear,
    input  DC_req, MD_req, VA_req, DC_cand, MD_cand, VA_cand,
    output DC_ack, MD_ack, VA_ack, reject, busy,
    output counter_DC_A, counter_DC_B, counter_DC_total,
    output counter_MD_A, counter_MD_B, counter_MD_total,
    output counter_VA_A, counter_VA_B, counter_VA_total,
    output counter_A, counter_B, counter_total
  );
endinterface

// File: rtl/vote_tally_arbiter.sv
// Round-robin arbiter sharing one counter-update path between the DC, MD and VA booths,
// holding the twelve saturating display counters with open/clear gating.
module vote_tally_arbiter #(
  parameter int CW        = 29,
  parameter int MAX_COUNT = 9999999
) (
  input  logic                clk,
  input  logic                rst,
  vote_tally_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    DC = 2'd0,
    MD = 2'd1,
    VA = 2'd2
  } booth_e;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] CAP = CW'(MAX_COUNT);

  booth_e        rr_last;
  booth_e        winner;
  logic          any_grant;
  logic          reject_q;
  logic [2:0]    req_v;
  logic [2:0]    cand_v;
  logic [2:0]    elig;
  logic [2:0]    ack_q;
  logic [CW-1:0] cnt_a [3];
  logic [CW-1:0] cnt_b [3];
  logic [CW-1:0] cnt_t [3];
  logic [CW-1:0] nat_a;
  logic [CW-1:0] nat_b;
  logic [CW-1:0] nat_t;

  function automatic booth_e next_booth(booth_e b);
    case (b)
      DC:      return MD;
      MD:      return VA;
      default: return DC;
    endcase
  endfunction

  assign req_v  = {bus.VA_req, bus.MD_req, bus.DC_req};
  assign cand_v = {bus.VA_cand, bus.MD_cand, bus.DC_cand};
  // A booth in its ack cycle still shows the old request, so it is masked out.
  assign elig   = req_v & ~ack_q & {3{bus.voting_open}};

  always_comb begin
    booth_e probe;
    // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
    winner    = DC;
    any_grant = 1'b0;
    probe     = rr_last;
    for (int k = 0; k < 3; k++) begin
      probe = next_booth(probe);
      if (!any_grant && elig[probe]) begin
        any_grant = 1'b1;
        winner    = probe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= '0;
      reject_q <= 1'b0;
      rr_last  <= VA;
      // NOTE: the counter arrays are display state, so unlike data memories they are reset.
      for (int r = 0; r < 3; r++) begin
        cnt_a[r] <= '0;
        cnt_b[r] <= '0;
        cnt_t[r] <= '0;
      end
      nat_a <= '0;
      nat_b <= '0;
      nat_t <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ack_q    <= '0;
      reject_q <= 1'b0;
      if (any_grant) begin
        ack_q[winner] <= 1'b1;
        rr_last       <= winner;
        if (nat_t == CAP) begin
          reject_q <= 1'b1;
        end else begin
          cnt_t[winner] <= cnt_t[winner] + ONE;
          nat_t         <= nat_t + ONE;
          if (cand_v[winner]) begin
            cnt_b[winner] <= cnt_b[winner] + ONE;
            nat_b         <= nat_b + ONE;
          end else begin
            cnt_a[winner] <= cnt_a[winner] + ONE;
            nat_a         <= nat_a + ONE;
          end
        end
      end else if (bus.clear && !bus.voting_open) begin
        for (int r = 0; r < 3; r++) begin
          cnt_a[r] <= '0;
          cnt_b[r] <= '0;
          cnt_t[r] <= '0;
        end
        nat_a <= '0;
        nat_b <= '0;
        nat_t <= '0;
      end
    end
  end

  assign bus.DC_ack           = ack_q[0];
  assign bus.MD_ack           = ack_q[1];
  assign bus.VA_ack           = ack_q[2];
  assign bus.reject           = reject_q;
  assign bus.busy             = bus.voting_open & |(req_v & ~ack_q);
  assign bus.counter_DC_A     = cnt_a[0];
  assign bus.counter_DC_B     = cnt_b[0];
  assign bus.counter_DC_total = cnt_t[0];
  assign bus.counter_MD_A     = cnt_a[1];
  assign bus.counter_MD_B     = cnt_b[1];
  assign bus.counter_MD_total = cnt_t[1];
  assign bus.counter_VA_A     = cnt_a[2];
  assign bus.counter_VA_B     = cnt_b[2];
  assign bus.counter_VA_total = cnt_t[2];
  assign bus.counter_A        = nat_a;
  assign bus.counter_B        = nat_b;
  assign bus.counter_total    = nat_t;

endmodule

// File: tb/tb_vote_tally_arbiter.sv
// Self-checking bench for vote_tally_arbiter: directed scenarios plus a randomized run
// compared against a vote-count model kept as plain per-region/per-candidate tallies.
module tb_vote_tally_arbiter;

  localparam int CW     = 29;
  localparam int TB_MAX = 5;

  typedef struct packed {
    logic [CW-1:0] dc_a, dc_b, dc_t;
    logic [CW-1:0] md_a, md_b, md_t;
    logic [CW-1:0] va_a, va_b, va_t;
    logic [CW-1:0] a, b, t;
  } cnt_s;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       t_open  = 1'b0;
  logic       t_clear = 1'b0;
  logic [2:0] t_req   = '0;
  logic [2:0] t_cand  = '0;

  int checks = 0;
  int errors = 0;

  int         m_votes [3][2];
  logic [1:0] m_last;
  logic [2:0] m_ack;
  logic       m_rej;

  always #5 clk = ~clk;

  vote_tally_arbiter_if #(.CW(CW)) bif ();

  assign bif.voting_open = t_open;
  assign bif.clear       = t_clear;
  assign bif.DC_req      = t_req[0];
  assign bif.MD_req      = t_req[1];
  assign bif.VA_req      = t_req[2];
  assign bif.DC_cand     = t_cand[0];
  assign bif.MD_cand     = t_cand[1];
  assign bif.VA_cand     = t_cand[2];

  vote_tally_arbiter #(.CW(CW), .MAX_COUNT(TB_MAX)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  function automatic int m_total();
    int s = 0;
    for (int r = 0; r < 3; r++) s += m_votes[r][0] + m_votes[r][1];
    return s;
  endfunction

  function automatic cnt_s mdl_cnt();
    cnt_s e;
    e.dc_a = CW'(m_votes[0][0]);
    e.dc_b = CW'(m_votes[0][1]);
    e.dc_t = CW'(m_votes[0][0] + m_votes[0][1]);
    e.md_a = CW'(m_votes[1][0]);
    e.md_b = CW'(m_votes[1][1]);
    e.md_t = CW'(m_votes[1][0] + m_votes[1][1]);
    e.va_a = CW'(m_votes[2][0]);
    e.va_b = CW'(m_votes[2][1]);
    e.va_t = CW'(m_votes[2][0] + m_votes[2][1]);
    e.a    = CW'(m_votes[0][0] + m_votes[1][0] + m_votes[2][0]);
    e.b    = CW'(m_votes[0][1] + m_votes[1][1] + m_votes[2][1]);
    e.t    = CW'(m_total());
    return e;
  endfunction

  function automatic cnt_s dut_cnt();
    return {bif.counter_DC_A, bif.counter_DC_B, bif.counter_DC_total,
            bif.counter_MD_A, bif.counter_MD_B, bif.counter_MD_total,
            bif.counter_VA_A, bif.counter_VA_B, bif.counter_VA_total,
            bif.counter_A, bif.counter_B, bif.counter_total};
  endfunction

  function automatic logic [2:0] dut_ack();
    return {bif.VA_ack, bif.MD_ack, bif.DC_ack};
  endfunction

  function automatic logic m_busy();
    return t_open && |(t_req & ~m_ack);
  endfunction

  function automatic void m_zero();
    for (int r = 0; r < 3; r++) begin
      m_votes[r][0] = 0;
      m_votes[r][1] = 0;
    end
  endfunction

  // Advance the model by one clock using the inputs currently driven, then let the DUT clock.
  task automatic tick();
    int w;
    if (rst) begin
      m_zero();
      m_last = 2'd2;
      m_ack  = '0;
      m_rej  = 1'b0;
    end else begin
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        logic [1:0] j;
        j = 2'((int'(m_last) + k) % 3);
        if (w < 0 && t_req[j] && !m_ack[j] && t_open) w = int'(j);
      end
      m_ack = '0;
      m_rej = 1'b0;
      if (w >= 0) begin
        m_last = 2'(w);
        m_ack[w] = 1'b1;
        if (m_total() == TB_MAX) m_rej = 1'b1;
        else m_votes[w][int'(t_cand[w])]++;
      end else if (t_clear && !t_open) begin
        m_zero();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; t_open = 1'b0; t_clear = 1'b0; t_req = '0; t_cand = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; t_open = 1'b0; t_clear = 1'b0; t_req = '0; t_cand = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (dut_cnt() !== '0) begin
      errors++; $display("FAIL reset_counters got=%h exp=0", dut_cnt());
    end
    checks++;
    if (dut_ack() !== 3'b000) begin
      errors++; $display("FAIL reset_acks got=%b exp=000", dut_ack());
    end
    checks++;
    if (bif.reject !== 1'b0) begin
      errors++; $display("FAIL reset_reject got=%b exp=0", bif.reject);
    end
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", bif.busy);
    end
  endtask

  task automatic test_single_vote();
    cnt_s e;
    do_reset();
    t_open = 1'b1; t_req[1] = 1'b1; t_cand[1] = 1'b1;
    #1;
    checks++;
    if (bif.busy !== 1'b1) begin
      errors++; $display("FAIL single_busy got=%b exp=1", bif.busy);
    end
    tick();
    t_req[1] = 1'b0;
    checks++;
    if (dut_ack() !== 3'b010 || bif.reject !== 1'b0) begin
      errors++; $display("FAIL single_ack got=%b rej=%b exp=010 rej=0", dut_ack(), bif.reject);
    end
    e = '0; e.md_b = 1; e.md_t = 1; e.b = 1; e.t = 1;
    checks++;
    if (dut_cnt() !== e) begin
      errors++; $display("FAIL single_counters got=%h exp=%h", dut_cnt(), e);
    end
    tick();
    checks++;
    if (dut_ack() !== 3'b000) begin
      errors++; $display("FAIL single_ack_pulse got=%b exp=000", dut_ack());
    end
  endtask

  task automatic test_contention();
    cnt_s e;
    do_reset();
    t_open = 1'b1; t_req = 3'b111; t_cand = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i > 0) t_req[i-1] = 1'b0;
      checks++;
      if (dut_ack() !== 3'(1 << i)) begin
        errors++; $display("FAIL contention_order step=%0d got=%b exp=%b", i, dut_ack(), 3'(1 << i));
      end
    end
    tick();
    t_req = '0;
    checks++;
    if (dut_ack() !== 3'b000) begin
      errors++; $display("FAIL contention_idle got=%b exp=000", dut_ack());
    end
    e = '0; e.dc_a = 1; e.dc_t = 1; e.md_a = 1; e.md_t = 1; e.va_a = 1; e.va_t = 1;
    e.a = 3; e.t = 3;
    checks++;
    if (dut_cnt() !== e) begin
      errors++; $display("FAIL contention_counters got=%h exp=%h", dut_cnt(), e);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    do_reset();
    t_open = 1'b1; t_req[0] = 1'b1; t_cand[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bif.DC_ack === 1'b1) n++;
      checks++;
      if (bif.DC_ack !== 1'((k % 2) == 0)) begin
        errors++; $display("FAIL b2b_pattern cycle=%0d got=%b exp=%b", k, bif.DC_ack, (k % 2) == 0);
      end
    end
    t_req = '0;
    tick();
    checks++;
    if (n != 4 || bif.counter_DC_B !== CW'(4) || bif.counter_total !== CW'(4)) begin
      errors++; $display("FAIL b2b_count acks=%0d dc_b=%0d total=%0d exp=4", n,
                         bif.counter_DC_B, bif.counter_total);
    end
  endtask

  task automatic test_saturation();
    int n, cyc;
    n = 0; cyc = 0;
    do_reset();
    t_open = 1'b1; t_req[0] = 1'b1; t_cand[0] = 1'b0;
    while (n < 7 && cyc < 40) begin
      tick();
      cyc++;
      if (bif.DC_ack === 1'b1) begin
        n++;
        checks++;
        if (bif.reject !== 1'(n > TB_MAX)) begin
          errors++; $display("FAIL sat_reject ack=%0d got=%b exp=%b", n, bif.reject, n > TB_MAX);
        end
      end else begin
        checks++;
        if (bif.reject !== 1'b0) begin
          errors++; $display("FAIL sat_reject_idle cycle=%0d got=%b exp=0", cyc, bif.reject);
        end
      end
    end
    t_req = '0;
    checks++;
    if (n != 7) begin
      errors++; $display("FAIL sat_timeout acks=%0d exp=7", n);
    end
    tick();
    checks++;
    if (bif.counter_DC_A !== CW'(TB_MAX) || bif.counter_total !== CW'(TB_MAX)) begin
      errors++; $display("FAIL sat_counters dc_a=%0d total=%0d exp=%0d", bif.counter_DC_A,
                         bif.counter_total, TB_MAX);
    end
  endtask

  task automatic test_gating();
    do_reset();
    t_open = 1'b1; t_req[1] = 1'b1; t_cand[1] = 1'b0;
    tick();
    t_req[1] = 1'b0;
    tick();
    t_open = 1'b0; t_req[2] = 1'b1; t_cand[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bif.busy !== 1'b0) begin
        errors++; $display("FAIL gate_busy cycle=%0d got=%b exp=0", k, bif.busy);
      end
      tick();
      checks++;
      if (dut_ack() !== 3'b000 || dut_cnt() !== mdl_cnt() || bif.counter_MD_A !== CW'(1)) begin
        errors++; $display("FAIL gate_hold cycle=%0d ack=%b got=%h exp=%h", k, dut_ack(),
                           dut_cnt(), mdl_cnt());
      end
    end
    t_clear = 1'b1;
    tick();
    t_clear = 1'b0;
    checks++;
    if (dut_cnt() !== '0) begin
      errors++; $display("FAIL gate_clear got=%h exp=0", dut_cnt());
    end
    t_open = 1'b1;
    tick();
    checks++;
    if (dut_ack() !== 3'b100 || bif.counter_VA_B !== CW'(1)) begin
      errors++; $display("FAIL gate_open_ack got=%b va_b=%0d exp=100 va_b=1", dut_ack(),
                         bif.counter_VA_B);
    end
    t_req = '0;
    tick();
  endtask

  task automatic test_reset_mid_vote();
    do_reset();
    t_open = 1'b1; t_req[0] = 1'b1; t_cand[0] = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (bif.DC_ack !== 1'b0 || dut_cnt() !== '0) begin
      errors++; $display("FAIL rstmid_during ack=%b got=%h exp ack=0 cnt=0", bif.DC_ack, dut_cnt());
    end
    rst = 1'b0; t_req = '0;
    tick();
    checks++;
    if (bif.DC_ack !== 1'b0 || dut_cnt() !== '0) begin
      errors++; $display("FAIL rstmid_after ack=%b got=%h exp ack=0 cnt=0", bif.DC_ack, dut_cnt());
    end
  endtask

  task automatic test_random();
    logic [2:0] seen;
    seen = '0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0) t_open = ~t_open;
      t_clear = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 3; i++) begin
        if (seen[i]) begin
          seen[i]   = 1'b0;
          t_req[i]  = 1'($urandom_range(0, 1));
          t_cand[i] = 1'($urandom_range(0, 1));
        end else if (m_ack[i]) begin
          seen[i] = 1'b1;
        end else if (!t_req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            t_req[i]  = 1'b1;
            t_cand[i] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          t_req[i] = 1'b0;
        end
      end
      #1;
      checks++;
      if (bif.busy !== m_busy()) begin
        errors++; $display("FAIL rand_busy cycle=%0d got=%b exp=%b", cyc, bif.busy, m_busy());
      end
      tick();
      checks++;
      if (dut_ack() !== m_ack || bif.reject !== m_rej) begin
        errors++; $display("FAIL rand_ack cycle=%0d got=%b rej=%b exp=%b rej=%b", cyc, dut_ack(),
                           bif.reject, m_ack, m_rej);
      end
      checks++;
      if (dut_cnt() !== mdl_cnt()) begin
        errors++; $display("FAIL rand_counters cycle=%0d got=%h exp=%h", cyc, dut_cnt(), mdl_cnt());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_zero();
    m_last = 2'd2;
    m_ack  = '0;
    m_rej  = 1'b0;
    test_reset();
    test_single_vote();
    test_contention();
    test_back_to_back();
    test_saturation();
    test_gating();
    test_reset_mid_vote();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
